// File: rtl/vga_pattern_timing_gen_if.sv
// Pixel-side bundle of the VGA timing / test-pattern generator.
//   mode        pattern select (0 bars, 1 checker, 2 solid, 3 gradient)
//   solid_rgb   {R,G,B} used by the solid pattern
//   H_sync      horizontal sync
//   V_sync      vertical sync
//   Red/Green/Blue colour channels, COLOR_W bits each
//   de          high while the presented pixel is visible
//   pix_x/pix_y coordinates of the presented pixel (also during blanking)
//   frame_start one-clk pulse when pixel (0,0) is presented
// XW/YW must equal $clog2 of the generator's horizontal/vertical totals.
// master = generator side, slave = display/overlay side.
interface vga_pattern_timing_gen_if #(
  parameter int unsigned COLOR_W = 4,
  parameter int unsigned XW      = 10,
  parameter int unsigned YW      = 10
);
  logic [1:0]           mode;
  logic [3*COLOR_W-1:0] solid_rgb;
  logic                 H_sync;
  logic                 V_sync;
  logic [COLOR_W-1:0]   Red;
  logic [COLOR_W-1:0]   Green;
  logic [COLOR_W-1:0]   Blue;
  logic                 de;
  logic [XW-1:0]        pix_x;
  logic [YW-1:0]        pix_y;
  logic                 frame_start;

  modport master (
    input  mode, solid_rgb,
    output H_sync, V_sync, Red, Green, Blue, de, pix_x, pix_y, frame_start
  );

  modport slave (
    output mode, solid_rgb,
    input  H_sync, V_sync, Red, Green, Blue, de, pix_x, pix_y, frame_start
  );
endinterface

// File: rtl/vga_pattern_timing_gen.sv
// Parametrised VGA timing and test-pattern generator.
// A clock divider produces a pixel tick; horizontal/vertical counters advance
// on that tick and every output is registered from the pre-increment counts,
// so outputs lag the counters by exactly one pixel tick.
// Ports:
//   clk    system clock
//   reset  asynchronous, active-low reset
//   vif    vga_pattern_timing_gen_if.master (mode/solid_rgb in, video out)
module vga_pattern_timing_gen #(
  parameter int unsigned CLK_DIV  = 2,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0,
  parameter int unsigned COLOR_W  = 4,
  parameter int unsigned CHK_LOG2 = 5
) (
  input  logic                       clk,
  input  logic                       reset,
  vga_pattern_timing_gen_if.master   vif
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned XW      = $clog2(H_TOTAL);
  localparam int unsigned YW      = $clog2(V_TOTAL);
  localparam int unsigned DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned BAR_W   = H_ACTIVE / 8;
  localparam int unsigned CW3     = 3 * COLOR_W;

  localparam logic [DW-1:0]      DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [XW-1:0]      H_LAST   = XW'(H_TOTAL - 1);
  localparam logic [YW-1:0]      V_LAST   = YW'(V_TOTAL - 1);
  localparam logic [XW-1:0]      HS_START = XW'(H_ACTIVE + H_FP);
  localparam logic [XW-1:0]      HS_END   = XW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [YW-1:0]      VS_START = YW'(V_ACTIVE + V_FP);
  localparam logic [YW-1:0]      VS_END   = YW'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [COLOR_W-1:0] MAX      = '1;

  // Gradient x*(MAX+1)/H_ACTIVE as a reciprocal multiply. With
  // GS >= XW + log2(H_ACTIVE) the rounding error of GK stays below one LSB
  // of the true quotient for every x < 2**XW, so the result is exact.
  localparam int unsigned GS = XW + $clog2(H_ACTIVE) + 1;
  localparam logic [63:0] GK = ((64'd1 << (GS + COLOR_W)) + 64'(H_ACTIVE) - 64'd1)
                               / 64'(H_ACTIVE);

  typedef enum logic [1:0] {
    PAT_BARS  = 2'd0,
    PAT_CHECK = 2'd1,
    PAT_SOLID = 2'd2,
    PAT_GRAD  = 2'd3
  } pat_e;

  logic [DW-1:0]  r_div_cnt;
  logic [XW-1:0]  r_h_cnt;
  logic [YW-1:0]  r_v_cnt;
  pat_e           r_mode_q;
  logic [CW3-1:0] r_solid_q;

  logic           r_hs;
  logic           r_vs;
  logic           r_de;
  logic           r_fs;
  logic [CW3-1:0] r_rgb;
  logic [XW-1:0]  r_pix_x;
  logic [YW-1:0]  r_pix_y;

  logic           w_pix_en;
  logic           w_h_last;
  logic           w_v_last;
  logic           w_de;
  logic           w_hs;
  logic           w_vs;
  logic [2:0]     w_bar_idx;
  logic [2:0]     w_bar_c;
  logic           w_chk;
  logic [63:0]    w_grad_raw;
  logic [COLOR_W-1:0] w_grad;
  logic [CW3-1:0] w_rgb;

  assign w_pix_en = (r_div_cnt == DIV_LAST);
  assign w_h_last = (r_h_cnt == H_LAST);
  assign w_v_last = (r_v_cnt == V_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_div_cnt <= '0;
      r_h_cnt   <= '0;
      r_v_cnt   <= '0;
    end else begin
      r_div_cnt <= w_pix_en ? '0 : r_div_cnt + 1'b1;
      if (w_pix_en) begin
        if (w_h_last) begin
          r_h_cnt <= '0;
          r_v_cnt <= w_v_last ? '0 : r_v_cnt + 1'b1;
        end else begin
          r_h_cnt <= r_h_cnt + 1'b1;
        end
      end
    end
  end

  // Pattern selection only changes on the last pixel of a frame, so the
  // next presented pixel (0,0) is the first one to use it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mode_q  <= PAT_BARS;
      r_solid_q <= '0;
    end else if (w_pix_en && w_h_last && w_v_last) begin
      r_mode_q  <= pat_e'(vif.mode);
      r_solid_q <= vif.solid_rgb;
    end
  end

  always_comb begin
    w_de = (r_h_cnt < XW'(H_ACTIVE)) && (r_v_cnt < YW'(V_ACTIVE));
    w_hs = ((r_h_cnt >= HS_START) && (r_h_cnt <= HS_END)) ? HS_POL : ~HS_POL;
    w_vs = ((r_v_cnt >= VS_START) && (r_v_cnt <= VS_END)) ? VS_POL : ~VS_POL;

    // Bar index by threshold compare, clamped to 7 for the remainder pixels.
    w_bar_idx = '0;
    for (int unsigned i = 1; i < 8; i++) begin
      if (32'(r_h_cnt) >= i * BAR_W) w_bar_idx = 3'(i);
    end
    w_bar_c = 3'd7 - w_bar_idx;

    w_chk = ((32'(r_h_cnt) ^ 32'(r_v_cnt)) & (32'd1 << CHK_LOG2)) != '0;

    w_grad_raw = (64'(r_h_cnt) * GK) >> GS;
    w_grad     = (w_grad_raw > 64'(MAX)) ? MAX : w_grad_raw[COLOR_W-1:0];

    w_rgb = '0;
    if (w_de) begin
      case (r_mode_q)
        PAT_BARS:  w_rgb = {{COLOR_W{w_bar_c[2]}}, {COLOR_W{w_bar_c[1]}},
                            {COLOR_W{w_bar_c[0]}}};
        PAT_CHECK: w_rgb = {CW3{w_chk}};
        PAT_SOLID: w_rgb = r_solid_q;
        PAT_GRAD:  w_rgb = {3{w_grad}};
        default:   w_rgb = '0;
      endcase
    end
  end

  // frame_start is re-evaluated every clk so it lasts one clk even when a
  // pixel is held for several clks.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hs    <= ~HS_POL;
      r_vs    <= ~VS_POL;
      r_de    <= 1'b0;
      r_fs    <= 1'b0;
      r_rgb   <= '0;
      r_pix_x <= '0;
      r_pix_y <= '0;
    end else begin
      r_fs <= w_pix_en && (r_h_cnt == '0) && (r_v_cnt == '0);
      if (w_pix_en) begin
        r_hs    <= w_hs;
        r_vs    <= w_vs;
        r_de    <= w_de;
        r_rgb   <= w_rgb;
        r_pix_x <= r_h_cnt;
        r_pix_y <= r_v_cnt;
      end
    end
  end

  assign vif.H_sync      = r_hs;
  assign vif.V_sync      = r_vs;
  assign vif.de          = r_de;
  assign vif.frame_start = r_fs;
  assign vif.Red         = r_rgb[CW3-1 -: COLOR_W];
  assign vif.Green       = r_rgb[2*COLOR_W-1 -: COLOR_W];
  assign vif.Blue        = r_rgb[COLOR_W-1:0];
  assign vif.pix_x       = r_pix_x;
  assign vif.pix_y       = r_pix_y;

endmodule

// File: tb/tb_vga_pattern_timing_gen.sv
// Bench for vga_pattern_timing_gen.
// Instance A: default horizontal timing, CLK_DIV=2, short frame (V 4/1/2/1).
// Instance B: CLK_DIV=1, positive syncs, H 8/2/2/2, V 4/1/1/1, CHK_LOG2=1.
// Expected pixels are queued per instance as stimulus is applied; a monitor
// per instance pops and compares when the DUT presents that coordinate.
module tb_vga_pattern_timing_gen;

  logic clk = 1'b0;
  logic rst_a_n;
  logic rst_b_n;
  int   n_checks = 0;
  int   n_errors = 0;
  event a_rel;
  event b_rel;

  initial forever #5 clk = ~clk;

  vga_pattern_timing_gen_if #(.COLOR_W(4), .XW(10), .YW(3)) ia ();
  vga_pattern_timing_gen_if #(.COLOR_W(4), .XW(4),  .YW(3)) ib ();

  vga_pattern_timing_gen #(
    .CLK_DIV(2), .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) dut_a (
    .clk(clk), .reset(rst_a_n), .vif(ia)
  );

  vga_pattern_timing_gen #(
    .CLK_DIV(1), .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .CHK_LOG2(1)
  ) dut_b (
    .clk(clk), .reset(rst_b_n), .vif(ib)
  );

  typedef struct { int x; int y; logic [15:0] e; } item_t;
  item_t qa[$];
  item_t qb[$];

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Packed pixel: {de, H_sync, V_sync, frame_start, R, G, B}
  function automatic logic [15:0] pk(bit de, bit hs, bit vs, bit fs, logic [11:0] rgb);
    return {de, hs, vs, fs, rgb};
  endfunction

  function automatic void push_a(int x, int y, bit de, bit hs, bit vs, bit fs, logic [11:0] rgb);
    item_t it;
    it.x = x; it.y = y; it.e = pk(de, hs, vs, fs, rgb);
    qa.push_back(it);
  endfunction

  function automatic void push_b(int x, int y, bit de, bit hs, bit vs, bit fs, logic [11:0] rgb);
    item_t it;
    it.x = x; it.y = y; it.e = pk(de, hs, vs, fs, rgb);
    qb.push_back(it);
  endfunction

  // Monitors: a presentation event is a coordinate change or a frame_start.
  initial begin : mon_a
    int px; int py; item_t it;
    px = 0; py = 0;
    forever begin
      @(negedge clk);
      if (rst_a_n === 1'b1 && (int'(ia.pix_x) != px || int'(ia.pix_y) != py || ia.frame_start === 1'b1)
          && qa.size() != 0 && qa[0].x == int'(ia.pix_x) && qa[0].y == int'(ia.pix_y)) begin
        it = qa.pop_front();
        check($sformatf("A(%0d,%0d)", it.x, it.y),
              pk(ia.de, ia.H_sync, ia.V_sync, ia.frame_start, {ia.Red, ia.Green, ia.Blue}), it.e);
      end
      px = int'(ia.pix_x); py = int'(ia.pix_y);
    end
  end

  initial begin : mon_b
    int px; int py; item_t it;
    px = 0; py = 0;
    forever begin
      @(negedge clk);
      if (rst_b_n === 1'b1 && (int'(ib.pix_x) != px || int'(ib.pix_y) != py || ib.frame_start === 1'b1)
          && qb.size() != 0 && qb[0].x == int'(ib.pix_x) && qb[0].y == int'(ib.pix_y)) begin
        it = qb.pop_front();
        check($sformatf("B(%0d,%0d)", it.x, it.y),
              pk(ib.de, ib.H_sync, ib.V_sync, ib.frame_start, {ib.Red, ib.Green, ib.Blue}), it.e);
      end
      px = int'(ib.pix_x); py = int'(ib.pix_y);
    end
  end

  // x < 0 means any x.
  task automatic wait_xy_a(input int x, input int y, input int budget);
    int n = 0;
    do begin
      @(negedge clk); n++;
    end while (!((x < 0 || int'(ia.pix_x) == x) && int'(ia.pix_y) == y) && n < budget);
    check($sformatf("reach_A(%0d,%0d)", x, y), n < budget, 1);
  endtask

  task automatic wait_fs_a(input int budget);
    int n = 0;
    do begin
      @(negedge clk); n++;
    end while (ia.frame_start !== 1'b1 && n < budget);
    check("reach_A_frame_start", n < budget, 1);
  endtask

  task automatic drain(input bit is_b, input int budget);
    int n = 0;
    while ((is_b ? qb.size() : qa.size()) != 0 && n < budget) begin
      @(negedge clk); n++;
    end
    check(is_b ? "drain_B" : "drain_A", is_b ? qb.size() : qa.size(), 0);
    if (is_b) qb.delete(); else qa.delete();
  endtask

  function automatic bit sig(int s);
    case (s)
      0:       return ia.H_sync;
      1:       return ia.V_sync;
      2:       return ~ia.de;
      3:       return ~ib.H_sync;
      4:       return ~ib.V_sync;
      default: return 1'b0;
    endcase
  endfunction

  // Clocks between two falling edges of sig(s), and clocks it stays low.
  task automatic meas(input int s, input int budget, output int per, output int low);
    bit prev; bit cur; bit found; int n;
    per = 0; low = 0; n = 0; found = 1'b0;
    prev = sig(s);
    while (!found && n < budget) begin
      @(negedge clk); n++; cur = sig(s); found = prev && !cur; prev = cur;
    end
    if (!found) return;
    low = 1; found = 1'b0;
    while (!found && n < budget) begin
      @(negedge clk); n++; per++; cur = sig(s); found = prev && !cur;
      if (!found && !cur) low++;
      prev = cur;
    end
    if (!found) per = 0;
  endtask

  task automatic chk_reset_a(input string name);
    check(name, {ia.H_sync, ia.V_sync, ia.de, ia.frame_start, ia.Red, ia.Green, ia.Blue,
                 ia.pix_x, ia.pix_y}, {4'b1100, 12'h000, 10'd0, 3'd0});
  endtask

  task automatic flow_a();
    bit ok; int prev;
    ia.mode = 2'd0; ia.solid_rgb = 12'h000;
    rst_a_n = 1'b1; #1 rst_a_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_a("A_reset_init");
    // Frame 1: bars (mode_q cleared by reset)
    push_a(0, 0, 1, 1, 1, 1, 12'hFFF);    push_a(79, 0, 1, 1, 1, 0, 12'hFFF);
    push_a(80, 0, 1, 1, 1, 0, 12'hFF0);   push_a(159, 0, 1, 1, 1, 0, 12'hFF0);
    push_a(500, 0, 1, 1, 1, 0, 12'h00F);  push_a(560, 0, 1, 1, 1, 0, 12'h000);
    push_a(639, 0, 1, 1, 1, 0, 12'h000);  push_a(640, 0, 0, 1, 1, 0, 12'h000);
    push_a(656, 0, 0, 0, 1, 0, 12'h000);  push_a(751, 0, 0, 0, 1, 0, 12'h000);
    push_a(752, 0, 0, 1, 1, 0, 12'h000);  push_a(100, 3, 1, 1, 1, 0, 12'hFF0);
    push_a(0, 4, 0, 1, 1, 0, 12'h000);    push_a(0, 5, 0, 1, 0, 0, 12'h000);
    push_a(0, 6, 0, 1, 0, 0, 12'h000);    push_a(0, 7, 0, 1, 1, 0, 12'h000);
    -> a_rel;
    @(negedge clk) rst_a_n = 1'b1;
    wait_xy_a(-1, 2, 20000);
    ia.mode = 2'd2; ia.solid_rgb = 12'h5A3;
    push_a(0, 0, 1, 1, 1, 1, 12'h5A3);    push_a(639, 3, 1, 1, 1, 0, 12'h5A3);
    push_a(640, 3, 0, 1, 1, 0, 12'h000);  push_a(700, 3, 0, 0, 1, 0, 12'h000);
    wait_fs_a(20000);
    wait_xy_a(-1, 1, 5000);
    ia.mode = 2'd3;
    push_a(0, 0, 1, 1, 1, 1, 12'h000);    push_a(39, 0, 1, 1, 1, 0, 12'h000);
    push_a(40, 0, 1, 1, 1, 0, 12'h111);   push_a(79, 0, 1, 1, 1, 0, 12'h111);
    push_a(80, 0, 1, 1, 1, 0, 12'h222);   push_a(639, 0, 1, 1, 1, 0, 12'hFFF);
    push_a(320, 1, 1, 1, 1, 0, 12'h888);
    wait_fs_a(20000);
    ok = 1'b1; prev = 0;
    for (int i = 0; i < 640; i++) begin
      if (ia.de !== 1'b1 || int'(ia.Red) < prev) ok = 1'b0;
      prev = int'(ia.Red);
      repeat (2) @(negedge clk);
    end
    check("A_grad_monotonic", ok, 1);
    drain(1'b0, 3000);
    wait_xy_a(300, 2, 5000);
    #2 rst_a_n = 1'b0;
    #1 chk_reset_a("A_reset_async");
    push_a(0, 0, 1, 1, 1, 1, 12'hFFF);    push_a(85, 0, 1, 1, 1, 0, 12'hFF0);
    push_a(500, 0, 1, 1, 1, 0, 12'h00F);
    repeat (3) @(negedge clk);
    rst_a_n = 1'b1;
    drain(1'b0, 3000);
  endtask

  task automatic flow_b();
    ib.mode = 2'd1; ib.solid_rgb = 12'h000;
    rst_b_n = 1'b1; #1 rst_b_n = 1'b0;
    repeat (3) @(negedge clk);
    check("B_reset_init", {ib.H_sync, ib.V_sync, ib.de, ib.frame_start, ib.Red, ib.Green,
                           ib.Blue, ib.pix_x, ib.pix_y}, '0);
    // Frame 1: bars, one pixel per bar
    push_b(0, 0, 1, 0, 0, 1, 12'hFFF);    push_b(1, 0, 1, 0, 0, 0, 12'hFF0);
    push_b(6, 0, 1, 0, 0, 0, 12'h00F);    push_b(7, 0, 1, 0, 0, 0, 12'h000);
    push_b(8, 0, 0, 0, 0, 0, 12'h000);    push_b(10, 0, 0, 1, 0, 0, 12'h000);
    push_b(11, 0, 0, 1, 0, 0, 12'h000);   push_b(12, 0, 0, 0, 0, 0, 12'h000);
    push_b(0, 4, 0, 0, 0, 0, 12'h000);    push_b(0, 5, 0, 0, 1, 0, 12'h000);
    push_b(0, 6, 0, 0, 0, 0, 12'h000);
    // Frame 2: checker with 2-pixel squares
    push_b(0, 0, 1, 0, 0, 1, 12'h000);    push_b(1, 0, 1, 0, 0, 0, 12'h000);
    push_b(2, 0, 1, 0, 0, 0, 12'hFFF);    push_b(3, 0, 1, 0, 0, 0, 12'hFFF);
    push_b(4, 0, 1, 0, 0, 0, 12'h000);    push_b(6, 0, 1, 0, 0, 0, 12'hFFF);
    push_b(3, 1, 1, 0, 0, 0, 12'hFFF);    push_b(0, 2, 1, 0, 0, 0, 12'hFFF);
    push_b(2, 2, 1, 0, 0, 0, 12'h000);
    -> b_rel;
    @(negedge clk) rst_b_n = 1'b1;
    drain(1'b1, 600);
  endtask

  initial begin
    fork
      flow_a();
      flow_b();
      begin
        @(a_rel);
        fork
          begin int p; int l; meas(0, 5000, p, l);
            check("A_hs_period", p, 1600); check("A_hs_low", l, 192); end
          begin int p; int l; meas(1, 40000, p, l);
            check("A_vs_period", p, 12800); check("A_vs_low", l, 3200); end
          begin int p; int l; meas(2, 5000, p, l);
            check("A_de_period", p, 1600); check("A_de_high", l, 1280); end
        join
      end
      begin
        @(b_rel);
        fork
          begin int p; int l; meas(3, 200, p, l);
            check("B_hs_period", p, 14); check("B_hs_high", l, 2); end
          begin int p; int l; meas(4, 400, p, l);
            check("B_vs_period", p, 98); check("B_vs_high", l, 14); end
        join
      end
    join
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", n_errors, n_checks);
    $fatal(1, "watchdog");
  end

endmodule
